load_store_unit: RTL and testbench

Memory-access stage controller between the EX/MEM pipeline register and the data memory. It accepts one load or store request at a time, converts the byte address to the memory's word index, and drives byte-lane strobes for stores. For loads it absorbs the memory's one-cycle registered read latency, then extracts and sign- or zero-extends the byte, halfword or word. It holds the pipeline through a valid/ready handshake on both sides.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage between EX/MEM and a data memory with one-cycle registered reads.
// Define LSU_MISALIGN_TRAP_EN to report misaligned or reserved-size accesses instead of force-aligning them.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [31:0]       mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] req_word;
    logic        req_err;
    logic [1:0]  eff_size;
    logic [1:0]  eff_lo;
    logic [3:0]  store_strb;
    logic [31:0] store_wdata;
    logic [1:0]  load_size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_word = 32'(req_addr >> 2);

    // Classify the incoming request: error detection and the effective size / low address bits.
    always_comb begin
        req_err  = 1'b0;
        eff_size = req_size;
        eff_lo   = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == 2'b11) begin
            eff_size = 2'b10;
        end
        case (eff_size)
            2'b01:   eff_lo = {req_addr[1], 1'b0};
            2'b10:   eff_lo = 2'b00;
            default: eff_lo = req_addr[1:0];
        endcase
`endif
    end

    always_comb begin
        store_strb  = 4'b1111;
        store_wdata = 32'(req_wdata);
        case (eff_size)
            2'b00: begin
                store_strb  = 4'b0001 << eff_lo;
                store_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_strb  = 4'b0011 << eff_lo;
                store_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                store_strb  = 4'b1111;
                store_wdata = 32'(req_wdata);
            end
        endcase
    end

    // Lane extraction for the word returned by memory during CAPTURE.
    always_comb begin
        load_size = (size_q == 2'b11) ? 2'b10 : size_q;
        case (addr_lo_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (load_size)
            2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_data = 32'(mem_rdata);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        signed_d   = signed_q;
        mem_addr_d = mem_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = '0;
        mem_addr   = mem_addr_q;
        mem_size   = size_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                mem_addr  = req_word;
                mem_size  = req_size;
                if (req_valid) begin
                    mem_addr_d = req_word;
                    size_d     = req_size;
                    addr_lo_d  = eff_lo;
                    signed_d   = req_signed;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if (req_err) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (req_we) begin
                        mem_we    = 1'b1;
                        mem_wstrb = store_strb;
                        mem_wdata = DATA_W'(store_wdata);
                        state_d   = RESP;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                rsp_data_d = load_data;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_lo_q  <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            mem_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            mem_addr_q <= mem_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = DATA_W'(rsp_data_q);
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small registered-read memory model plus a response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        preload_en;
    logic [3:0]  preload_idx;
    logic [31:0] preload_val;
    logic [31:0] mem [16];

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   rsp_count  = 0;
    int   exp_rsp    = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Data memory with byte-lane writes and a one-cycle registered read.
    always @(posedge clk) begin
        if (preload_en) begin
            mem[preload_idx] <= preload_val;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb[k]) mem[mem_addr[3:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
        mem_rdata <= mem[mem_addr[3:0]];
    end

    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        preload_idx = idx;
        preload_val = val;
        preload_en  = 1'b1;
        cycle();
        preload_en  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input logic exp_err,
                                 input bit expect_rsp);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        if (expect_rsp) begin
            sb.push_back('{data: exp_data, err: exp_err});
            exp_rsp++;
        end
        #1;
    endtask

    task automatic waitResponse(input string tag, input int exp_lat);
        exp_t e;
        int   lat;
        cycle();
        req_valid = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            cycle();
            #1;
            lat++;
        end
        checkOutput({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (rsp_valid) begin
                checkOutput({tag, "_data"}, rsp_data, e.data);
                checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    endtask

    task automatic finishResp(input string tag);
        cycle();
        #1;
        checkOutput({tag, "_ready_again"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b1;
        preload_en  = 1'b0;
        preload_idx = '0;
        preload_val = '0;

        cycle();
        preload(4'd0, 32'h1122_3344);
        preload(4'd1, 32'h8001_0000);
        preload(4'd2, 32'd30);
        preload(4'd3, 32'h0000_0000);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);

        // Load word from byte address 0x8 (word 2 holds 30).
        cycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0000_001E, 1'b0, 1'b1);
        checkOutput("ldw_mem_addr", mem_addr, 32'd2);
        checkOutput("ldw_mem_we", {31'b0, mem_we}, 32'd0);
        waitResponse("ldw", 2);
        checkOutput("ldw_latched_addr", mem_addr, 32'd2);
        finishResp("ldw");

        // Store byte 0xFF at 0x5.
        cycle();
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
        checkOutput("stb_mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("stb_mem_addr", mem_addr, 32'd1);
        checkOutput("stb_mem_wstrb", {28'b0, mem_wstrb}, 32'h2);
        checkOutput("stb_mem_wdata", mem_wdata, 32'hFFFF_FFFF);
        waitResponse("stb", 1);
        checkOutput("stb_we_one_cycle", {31'b0, mem_we}, 32'd0);
        checkOutput("stb_wstrb_idle", {28'b0, mem_wstrb}, 32'd0);
        finishResp("stb");

        cycle();
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        waitResponse("ldb_s", 2);
        finishResp("ldb_s");

        cycle();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'h0000_00FF, 1'b0, 1'b1);
        waitResponse("ldb_u", 2);
        finishResp("ldb_u");

        // Half at 0x6: word 1 upper lanes hold 0x8001.
        cycle();
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
        checkOutput("ldh_mem_size", {30'b0, mem_size}, 32'd1);
        waitResponse("ldh_s", 2);
        finishResp("ldh_s");

        cycle();
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
        waitResponse("ldh_u", 2);
        finishResp("ldh_u");

        // Store half 0xABCD at 0x2 -> word 0 becomes 0xABCD3344.
        cycle();
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_ABCD, 32'h0, 1'b0, 1'b1);
        checkOutput("sth_mem_addr", mem_addr, 32'd0);
        checkOutput("sth_mem_wstrb", {28'b0, mem_wstrb}, 32'hC);
        checkOutput("sth_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        waitResponse("sth", 1);
        finishResp("sth");

        cycle();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0044, 1'b0, 1'b1);
        waitResponse("ldb0", 2);
        finishResp("ldb0");

        cycle();
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 32'h0000_0033, 1'b0, 1'b1);
        waitResponse("ldb1", 2);
        finishResp("ldb1");

        // Misaligned half and reserved size.
`ifdef LSU_MISALIGN_TRAP_EN
        cycle();
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_h_mem_we", {31'b0, mem_we}, 32'd0);
        waitResponse("mis_h", 1);
        finishResp("mis_h");

        cycle();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hE, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_sw_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("mis_sw_wstrb", {28'b0, mem_wstrb}, 32'd0);
        waitResponse("mis_sw", 1);
        finishResp("mis_sw");

        cycle();
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 1'b1);
        waitResponse("rsvd", 1);
        finishResp("rsvd");
`else
        cycle();
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0000_ABCD, 1'b0, 1'b1);
        waitResponse("mis_h", 2);
        finishResp("mis_h");

        cycle();
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0000_001E, 1'b0, 1'b1);
        waitResponse("rsvd", 2);
        finishResp("rsvd");
`endif

        // Store word then read it back.
        cycle();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        checkOutput("stw_mem_addr", mem_addr, 32'd3);
        checkOutput("stw_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
        checkOutput("stw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        waitResponse("stw", 1);
        finishResp("stw");

        cycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        waitResponse("ldw_c", 2);
        finishResp("ldw_c");

        // Consumer back-pressure in RESP.
        rsp_ready = 1'b0;
        cycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0000_001E, 1'b0, 1'b1);
        waitResponse("stall", 2);
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            checkOutput("stall_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall_data", rsp_data, 32'h0000_001E);
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        #1;
        checkOutput("stall_release_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("stall_release_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset while a load sits in CAPTURE.
        cycle();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        req_valid = 1'b0;
        #1;
        checkOutput("abort_capture_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("abort_capture_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("abort_rsp_data", rsp_data, 32'd0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            checkOutput("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end

        checkOutput("rsp_count", 32'(rsp_count), 32'(exp_rsp));
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
